// File: rtl/sequential_divider.sv
// Restoring shift-subtract unsigned divider with start/done handshake.
// One FSM state per shift or trial micro-step; fixed 2*WIDTH+3 cycle cadence.
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int SW = $clog2(2*WIDTH+3);

  localparam logic [SW-1:0] S_IDLE   = '0;
  localparam logic [SW-1:0] S_LOAD   = SW'(1);
  localparam logic [SW-1:0] S_SHIFT1 = SW'(2);
  localparam logic [SW-1:0] S_SHMAX  = SW'(2*WIDTH);
  localparam logic [SW-1:0] S_TRMIN  = SW'(3);
  localparam logic [SW-1:0] S_TRMAX  = SW'(2*WIDTH+1);
  localparam logic [SW-1:0] S_DONE   = SW'(2*(WIDTH+1));

  logic [SW-1:0]  state;
  logic [SW-1:0]  state_nx;

  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] d;
  logic             z;

  logic is_idle;
  logic is_load;
  logic is_shift;
  logic is_trial;
  logic is_done;
  logic is_bad;

  logic [WIDTH:0] d_ext;
  logic [WIDTH:0] r_diff;
  logic           r_ge;

  // Even codes are SHIFT steps, odd codes are TRIAL steps.
  always_comb begin
    is_idle  = (state == S_IDLE);
    is_load  = (state == S_LOAD);
    is_shift = !state[0]
             && (state >= S_SHIFT1)
             && (state <= S_SHMAX);
    is_trial = state[0]
             && (state >= S_TRMIN)
             && (state <= S_TRMAX);
    is_done  = (state == S_DONE);
    is_bad   = (state > S_DONE);
  end

  always_comb begin
    d_ext  = {1'b0, d};
    r_diff = r - d_ext;
    r_ge   = (r >= d_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // TRIAL_n + 1 is SHIFT_(n+1); after the last trial it lands on DONE.
  always_comb begin
    state_nx = S_IDLE;
    unique case (1'b1)
      is_idle:  state_nx = start ? S_LOAD : S_IDLE;
      is_load:  state_nx = S_SHIFT1;
      is_shift: state_nx = state + SW'(1);
      is_trial: state_nx = state + SW'(1);
      is_done:  state_nx = S_IDLE;
      is_bad:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
      z <= 1'b0;
    end else begin
      unique case (1'b1)
        is_load: begin
          q <= dividend;
          d <= divisor;
          r <= '0;
          z <= (divisor == '0);
        end
        is_shift: begin
          {r, q} <= {r[WIDTH-1:0], q, 1'b0};
        end
        is_trial: begin
          if (r_ge) begin
            r    <= r_diff;
            q[0] <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy        = !is_idle;
    done        = is_done;
    div_by_zero = is_done && z;
    quotient    = q;
    remainder   = r[WIDTH-1:0];
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider at WIDTH=4 and WIDTH=8.
// Expected results are queued at start and compared when done pulses.
module tb_sequential_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start4 = 1'b0;
  logic [3:0] dvd4 = '0;
  logic [3:0] dvs4 = '0;
  logic       busy4, done4, dbz4;
  logic [3:0] quo4, rem4;

  logic       start8 = 1'b0;
  logic [7:0] dvd8 = '0;
  logic [7:0] dvs8 = '0;
  logic       busy8, done8, dbz8;
  logic [7:0] quo8, rem8;

  sequential_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .dividend(dvd4), .divisor(dvs4),
    .busy(busy4), .done(done4), .div_by_zero(dbz4),
    .quotient(quo4), .remainder(rem4)
  );

  sequential_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .quotient(quo8), .remainder(rem8)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  exp_t sb4[$];
  exp_t sb8[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done4_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t ref_div(logic [7:0] a, logic [7:0] b, logic [7:0] ones);
    exp_t e;
    if (b == 0) begin
      e.q = ones;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done4) begin
      done4_cnt++;
      checks++;
      if (sb4.size() == 0) begin
        failures++;
        $display("FAIL done4_unexpected: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb4.pop_front();
        if (quo4 !== e.q[3:0] || rem4 !== e.r[3:0] || dbz4 !== e.z) begin
          failures++;
          $display("FAIL result4: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                   quo4, rem4, dbz4, e.q, e.r, e.z);
        end
      end
    end
    if (done8) begin
      checks++;
      if (sb8.size() == 0) begin
        failures++;
        $display("FAIL done8_unexpected: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb8.pop_front();
        if (quo8 !== e.q || rem8 !== e.r || dbz8 !== e.z) begin
          failures++;
          $display("FAIL result8: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                   quo8, rem8, dbz8, e.q, e.r, e.z);
        end
      end
    end
  end

  // Start one WIDTH=4 op; optionally verify done at +10 and busy shape.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input exp_t e, input bit timing);
    int done_at;
    bit busy_ok;
    @(negedge clk);
    dvd4 = a;
    dvs4 = b;
    start4 = 1'b1;
    sb4.push_back(e);
    @(posedge clk);
    #1 start4 = 1'b0;
    done_at = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done4 && done_at == 0) done_at = c;
      if (c <= 10 && !busy4) busy_ok = 1'b0;
      if (c >= 11 && busy4) busy_ok = 1'b0;
    end
    if (timing) begin
      chk("done_latency", done_at, 10);
      chk("busy_window", {31'd0, busy_ok}, 1);
    end else if (done_at == 0) begin
      chk("done4_timeout", done_at, 10);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int done_at;
    @(negedge clk);
    dvd8 = a;
    dvs8 = b;
    start8 = 1'b1;
    sb8.push_back(ref_div(a, b, 8'hff));
    @(posedge clk);
    #1 start8 = 1'b0;
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done8 && done_at == 0) done_at = c;
    end
    chk("done8_latency", done_at, 18);
  endtask

  vec_t vecs[6];

  initial begin
    int t0;
    int dt[3];
    int n;
    int dcnt;
    exp_t e;

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
    vecs[2] = '{a: 4'd5,  b: 4'd7,  q: 4'd0,  r: 4'd5, z: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd4,  q: 4'd0,  r: 4'd0, z: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_dbz", dbz4, 0);
    chk("rst_quo", quo4, 0);
    chk("rst_rem", rem4, 0);

    for (int i = 0; i < 6; i++) begin
      e.q = {4'd0, vecs[i].q};
      e.r = {4'd0, vecs[i].r};
      e.z = vecs[i].z;
      run4(vecs[i].a, vecs[i].b, e, 1'b1);
    end

    // Held start: back-to-back ops, done every 11 cycles.
    @(negedge clk);
    dvd4 = 4'd14;
    dvs4 = 4'd4;
    e = '{q: 8'd3, r: 8'd2, z: 1'b0};
    repeat (3) sb4.push_back(e);
    start4 = 1'b1;
    t0 = cyc;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (done4) begin
        dt[n] = cyc;
        n++;
      end
    end
    start4 = 1'b0;
    chk("held_ops", n, 3);
    if (n == 3) begin
      chk("held_first", dt[0] - t0, 10);
      chk("held_gap1", dt[1] - dt[0], 11);
      chk("held_gap2", dt[2] - dt[1], 11);
    end
    repeat (3) @(negedge clk);
    chk("held_idle", busy4, 0);

    // Operand change after LOAD must not affect the result.
    @(negedge clk);
    dvd4 = 4'd13;
    dvs4 = 4'd3;
    start4 = 1'b1;
    sb4.push_back('{q: 8'd4, r: 8'd1, z: 1'b0});
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (2) @(negedge clk);
    dvd4 = 4'd2;
    dvs4 = 4'd0;
    repeat (12) @(negedge clk);
    chk("chg_queue_empty", sb4.size(), 0);

    // Reset asserted during SHIFT_2 of 13/3.
    @(negedge clk);
    dvd4 = 4'd13;
    dvs4 = 4'd3;
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy_pre", busy4, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy4, 0);
    chk("midrst_quo", quo4, 0);
    chk("midrst_rem", rem4, 0);
    dcnt = done4_cnt;
    repeat (15) @(negedge clk);
    chk("midrst_no_done", done4_cnt - dcnt, 0);
    run4(4'd13, 4'd3, '{q: 8'd4, r: 8'd1, z: 1'b0}, 1'b1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(4'(a), 4'(b), ref_div(8'(a), 8'(b), 8'h0f), 1'b0);
      end
    end

    for (int i = 0; i < 150; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom_range(0, 255));
      b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run8(a, b);
    end
    run8(8'd255, 8'd1);
    run8(8'd0, 8'd0);
    run8(8'd200, 8'd255);

    chk("sb4_drained", sb4.size(), 0);
    chk("sb8_drained", sb8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
